// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: sequences fetch, decode, memory, ALU and branch steps.
// Optional feature macro: BRANCH_EXT_EN enables BNE/BLT/BGE/BLTU/BGEU (default build: BEQ only).
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_last_bit,
  output logic [3:0]  alu_control,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        illegal
);

  // state    | meaning
  // IDLE     | post-reset, all outputs quiet
  // FETCH    | read instruction at PC, PC+4 into PC on mem_ready
  // DECODE   | old PC + imm into ALU-out (branch/jump target)
  // MEMADR   | rs1 + imm effective address
  // MEMREAD  | load access, wait for mem_ready
  // MEMWB    | write load data to rd
  // MEMWRITE | store access, wait for mem_ready
  // EXECR    | register-register ALU op
  // EXECI    | register-immediate ALU op
  // ALUWB    | write ALU-out to rd
  // BRANCH   | compare rs1/rs2, load target on taken
  // JAL      | PC <= target, ALU-out <= old PC + 4
  // TRAP     | unsupported instruction, exit only by reset

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM      = 2'b01;
  localparam logic [1:0] RES_ALU_LIVE = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  state_t state, state_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       branch_legal;
  logic [3:0] branch_op;
  logic       branch_flag;
  logic       branch_taken;
  logic       unused_instr_bits;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

`ifdef BRANCH_EXT_EN
  assign branch_legal = (funct3[2:1] != 2'b01);
`else
  assign branch_legal = (funct3 == 3'b000);
`endif

  // sub_ok distinguishes R-type (ADD/SUB by funct7[5]) from I-type (always ADDI)
  function automatic logic [3:0] exec_op(input logic [2:0] f3, input logic f7b5,
                                         input logic sub_ok);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (sub_ok && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // funct3[0] inverts the sense: BNE, BGE, BGEU
  always_comb begin
    branch_op   = ALU_SUB;
    branch_flag = alu_zero;
    case (funct3[2:1])
      2'b10: begin
        branch_op   = ALU_SLT;
        branch_flag = alu_last_bit;
      end
      2'b11: begin
        branch_op   = ALU_SLTU;
        branch_flag = alu_last_bit;
      end
      default: begin
        branch_op   = ALU_SUB;
        branch_flag = alu_zero;
      end
    endcase
    branch_taken = funct3[0] ? ~branch_flag : branch_flag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_REG:            state_next = S_EXECR;
          OP_IMM:            state_next = S_EXECI;
          OP_BRANCH:         state_next = branch_legal ? S_BRANCH : S_TRAP;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    result_src  = RES_ALU_OUT;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_LIVE;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = exec_op(funct3, funct7_b5, 1'b1);
      end
      S_EXECI: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        alu_control = exec_op(funct3, funct7_b5, 1'b0);
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALU_OUT;
      end
      S_BRANCH: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = branch_op;
        pc_write    = branch_taken;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction reference model with random traffic.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic        alu_last_bit;
  logic [3:0]  alu_control;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        illegal;

  int checks;
  int failures;

  multicycle_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .alu_zero     (alu_zero),
    .alu_last_bit (alu_last_bit),
    .alu_control  (alu_control),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {alu_control, alu_src_a, alu_src_b, result_src,
                mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, illegal};

  // funct3 -> ALU code for the base (non-alternate) operations
  localparam logic [3:0] BASE_OP [8] = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};

  function automatic logic [16:0] v(input logic [3:0] alu, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] rs,
                                    input logic mreq, input logic mwe, input logic asel,
                                    input logic irw, input logic pcw, input logic rw,
                                    input logic ill);
    return {alu, sa, sb, rs, mreq, mwe, asel, irw, pcw, rw, ill};
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(1, 0));
  endfunction

  task automatic check(input logic [16:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h instr=%08h", tag, obs, exp, instr);
    end
  endtask

  task automatic step(input logic mr, input logic [16:0] exp, input string tag);
    @(negedge clk);
    mem_ready = mr;
    #1;
    check(exp, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check(17'h0, "reset_async");
    @(negedge clk);
    #1 check(17'h0, "reset_hold");
    rst_n = 1'b1;
    #1 check(17'h0, "idle");
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic z, input logic lb, input bit abort);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       alt;
    logic       legal_br;
    logic [3:0] op;
    logic       taken;
    instr        = ins;
    alu_zero     = z;
    alu_last_bit = lb;
    opc = ins[6:0];
    f3  = ins[14:12];
    alt = ins[30];
    for (int i = 0; i < fw; i++) step(1'b0, v(4'h0, 2'd0, 2'd2, 2'd2, 1, 0, 0, 0, 0, 0, 0), "fetch_wait");
    step(1'b1, v(4'h0, 2'd0, 2'd2, 2'd2, 1, 0, 0, 1, 1, 0, 0), "fetch");
    step(rb(), v(4'h0, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0), "decode");
`ifdef BRANCH_EXT_EN
    legal_br = !(f3 == 3'd2 || f3 == 3'd3);
`else
    legal_br = (f3 == 3'd0);
`endif
    if (opc == 7'b0000011 || opc == 7'b0100011) begin
      step(rb(), v(4'h0, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0), "memadr");
      if (opc == 7'b0000011) begin
        for (int i = 0; i < mw; i++) step(1'b0, v(4'h0, 2'd0, 2'd0, 2'd0, 1, 0, 1, 0, 0, 0, 0), "memread_wait");
        step(1'b1, v(4'h0, 2'd0, 2'd0, 2'd0, 1, 0, 1, 0, 0, 0, 0), "memread");
        step(rb(), v(4'h0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 1, 0), "memwb");
      end else begin
        for (int i = 0; i < mw; i++) step(1'b0, v(4'h0, 2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, 0), "memwrite_wait");
        if (abort) do_reset();
        else step(1'b1, v(4'h0, 2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, 0), "memwrite");
      end
    end else if (opc == 7'b0110011 || opc == 7'b0010011) begin
      op = BASE_OP[f3];
      if (alt && f3 == 3'd5) op = 4'h9;
      if (alt && f3 == 3'd0 && opc == 7'b0110011) op = 4'h1;
      if (opc == 7'b0110011) step(rb(), v(op, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0), "execr");
      else                   step(rb(), v(op, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0), "execi");
      step(rb(), v(4'h0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0), "aluwb");
    end else if (opc == 7'b1100011 && legal_br) begin
      // 00x: equality via SUB/zero, 10x: signed SLT, 11x: unsigned SLTU; odd funct3 negates
      op    = (f3[2] == 1'b0) ? 4'h1 : ((f3[1] == 1'b0) ? 4'h5 : 4'h6);
      taken = (f3[2] ? lb : z) ^ f3[0];
      step(rb(), v(op, 2'd2, 2'd0, 2'd0, 0, 0, 0, 0, taken, 0, 0), "branch");
    end else if (opc == 7'b1101111) begin
      step(rb(), v(4'h0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 1, 0, 0), "jal");
      step(rb(), v(4'h0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0), "jal_aluwb");
    end else begin
      for (int i = 0; i < 3; i++) step(rb(), v(4'h0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1), "trap");
      do_reset();
    end
  endtask

  initial begin
    logic [31:0] ins;
    int          kind;
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    instr        = 32'h0;
    mem_ready    = 1'b0;
    alu_zero     = 1'b0;
    alu_last_bit = 1'b0;
    repeat (2) @(negedge clk);
    #1 check(17'h0, "reset");
    rst_n = 1'b1;
    #1 check(17'h0, "idle_after_reset");

    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);  // add
    run_instr(32'h402081B3, 1, 0, 1'b0, 1'b0, 1'b0);  // sub
    run_instr(32'h4020D193, 0, 0, 1'b0, 1'b0, 1'b0);  // srai
    run_instr(32'h0080A283, 0, 2, 1'b0, 1'b0, 1'b0);  // lw, two wait cycles
    run_instr(32'h0020A423, 0, 1, 1'b0, 1'b0, 1'b0);  // sw
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0);  // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b1, 1'b0);  // beq not taken
    run_instr(32'h0020C463, 0, 0, 1'b0, 1'b1, 1'b0);  // blt
    run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0, 1'b0);  // jal
    run_instr(32'h00000000, 0, 0, 1'b0, 1'b0, 1'b0);  // illegal
    run_instr(32'h0020A423, 0, 2, 1'b0, 1'b0, 1'b1);  // sw, reset mid-wait
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      ins  = $urandom;
      kind = $urandom_range(6, 0);
      case (kind)
        0: ins[6:0] = 7'b0110011;
        1: ins[6:0] = 7'b0010011;
        2: ins[6:0] = 7'b0000011;
        3: ins[6:0] = 7'b0100011;
        4: ins[6:0] = 7'b1100011;
        5: ins[6:0] = 7'b1101111;
        default: ins[1:0] = 2'b00;
      endcase
      run_instr(ins, $urandom_range(2, 0), $urandom_range(2, 0), rb(), rb(), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
